ex_operand_stage: RTL and testbench

ID/EX pipeline register plus operand-forwarding and load-use detection for the 5-stage RV32I core. Captures decoded instructions from ID and presents registered, forwarded operands `alu_a`/`alu_b` and `alu_op` to the ALU in EX, along with the control bits EX/MEM needs. Handles stall, flush and bubble insertion so the ALU always sees either a valid instruction or a killed bubble.

---
 rtl/core_pkg.sv | 52 +++++
 rtl/fwd_unit.sv | 33 +++
 rtl/ex_operand_stage.sv | 117 +++++++++++
 tb/tb_ex_operand_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core types: datapath widths, ALU opcodes, forwarding selects
// and the ID/EX pipeline register layout.
package core_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_AND  = 4'd8,
    ALU_SUB  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            use_imm;
    logic            use_pc;
    alu_op_e         alu_op;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } id_ex_t;

  // A producer forwards only if it is live, writes a register, and that register is not x0.
  function automatic logic fwd_hit(input logic            v,
                                   input logic            rw,
                                   input logic [REGW-1:0] rd,
                                   input logic [REGW-1:0] rs);
    return v & rw & (rd != '0) & (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Selects the newest value of one source register from MEM, WB or the stored copy.
module fwd_unit
  import core_pkg::*;
(
  input  logic [REGW-1:0] i_rs,
  input  logic [XLEN-1:0] i_reg_data,
  input  logic            i_mem_valid,
  input  logic            i_mem_reg_write,
  input  logic [REGW-1:0] i_mem_rd,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_wb_valid,
  input  logic            i_wb_reg_write,
  input  logic [REGW-1:0] i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output fwd_sel_e        o_sel,
  output logic [XLEN-1:0] o_data
);

  // MEM is checked last so the younger producer wins.
  always_comb begin
    o_sel  = FWD_REG;
    o_data = i_reg_data;
    if (fwd_hit(i_wb_valid, i_wb_reg_write, i_wb_rd, i_rs)) begin
      o_sel  = FWD_WB;
      o_data = i_wb_data;
    end
    if (fwd_hit(i_mem_valid, i_mem_reg_write, i_mem_rd, i_rs)) begin
      o_sel  = FWD_MEM;
      o_data = i_mem_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with operand forwarding, capture bypass from WB and load-use detection.
// Handshake: ID advances whenever load_use_stall and hold are both low; flush kills EX unconditionally.
module ex_operand_stage
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_op,
  input  logic            id_use_imm,
  input  logic            id_use_pc,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            hold,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic [REGW-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_valid,
  input  logic            wb_reg_write,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [REGW-1:0] ex_rd,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_stall
);

  id_ex_t          r_ex;
  fwd_sel_e        w_sel1, w_sel2;
  logic [XLEN-1:0] w_fwd1, w_fwd2;
  logic [XLEN-1:0] w_cap1, w_cap2;

  fwd_unit u_fwd_rs1 (
    .i_rs(r_ex.rs1), .i_reg_data(r_ex.rs1_data),
    .i_mem_valid(mem_valid), .i_mem_reg_write(mem_reg_write), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
    .i_wb_valid(wb_valid), .i_wb_reg_write(wb_reg_write), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_sel(w_sel1), .o_data(w_fwd1)
  );

  fwd_unit u_fwd_rs2 (
    .i_rs(r_ex.rs2), .i_reg_data(r_ex.rs2_data),
    .i_mem_valid(mem_valid), .i_mem_reg_write(mem_reg_write), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
    .i_wb_valid(wb_valid), .i_wb_reg_write(wb_reg_write), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_sel(w_sel2), .o_data(w_fwd2)
  );

  // The register file is read before WB writes it, so the WB value replaces the stale read.
  assign w_cap1 = fwd_hit(wb_valid, wb_reg_write, wb_rd, id_rs1) ? wb_data : id_rs1_data;
  assign w_cap2 = fwd_hit(wb_valid, wb_reg_write, wb_rd, id_rs2) ? wb_data : id_rs2_data;

  assign load_use_stall = r_ex.valid & r_ex.mem_read & (r_ex.rd != '0) & id_valid &
                          ((r_ex.rd == id_rs1) | (r_ex.rd == id_rs2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex <= '0;
    end else if (flush) begin
      r_ex.valid     <= 1'b0;
      r_ex.reg_write <= 1'b0;
      r_ex.mem_read  <= 1'b0;
      r_ex.mem_write <= 1'b0;
    end else if (hold) begin
      // Latch forwarded values so they outlive the producer retiring during the stall.
      if (w_sel1 != FWD_REG) r_ex.rs1_data <= w_fwd1;
      if (w_sel2 != FWD_REG) r_ex.rs2_data <= w_fwd2;
    end else if (load_use_stall) begin
      r_ex.valid     <= 1'b0;
      r_ex.reg_write <= 1'b0;
      r_ex.mem_read  <= 1'b0;
      r_ex.mem_write <= 1'b0;
    end else begin
      r_ex.valid     <= id_valid;
      r_ex.reg_write <= id_valid & id_reg_write;
      r_ex.mem_read  <= id_valid & id_mem_read;
      r_ex.mem_write <= id_valid & id_mem_write;
      r_ex.use_imm   <= id_use_imm;
      r_ex.use_pc    <= id_use_pc;
      r_ex.alu_op    <= alu_op_e'(id_alu_op);
      r_ex.rd        <= id_rd;
      r_ex.rs1       <= id_rs1;
      r_ex.rs2       <= id_rs2;
      r_ex.pc        <= id_pc;
      r_ex.rs1_data  <= w_cap1;
      r_ex.rs2_data  <= w_cap2;
      r_ex.imm       <= id_imm;
    end
  end

  assign alu_a         = r_ex.use_pc  ? r_ex.pc  : w_fwd1;
  assign alu_b         = r_ex.use_imm ? r_ex.imm : w_fwd2;
  assign ex_store_data = w_fwd2;
  assign alu_op        = r_ex.alu_op;
  assign ex_valid      = r_ex.valid;
  assign ex_reg_write  = r_ex.reg_write;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;
  assign ex_rd         = r_ex.rd;
  assign ex_pc         = r_ex.pc;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: a vector table for the single-cycle paths
// plus hand-written sequences for stalls, hold refresh, flush and reset.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_use_imm, id_use_pc, id_reg_write, id_mem_read, id_mem_write;
  logic        hold, flush;
  logic        mem_valid, mem_reg_write, wb_valid, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_errors = 0;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .hold(hold), .flush(flush), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .mem_data(mem_data), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
    .load_use_stall(load_use_stall)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic        id_valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        use_imm, use_pc, rw;
    logic        cwb_v;
    logic [4:0]  cwb_rd;
    logic [31:0] cwb_d;
    logic        m_v, m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_d;
    logic        w_v, w_rw;
    logic [4:0]  w_rd;
    logic [31:0] w_d;
    logic        e_valid;
    logic [31:0] e_a, e_b, e_sd;
    logic [3:0]  e_op;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_op = 0;
    id_use_imm = 0; id_use_pc = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    hold = 0; flush = 0;
    mem_valid = 0; mem_reg_write = 0; mem_rd = 0; mem_data = 0;
    wb_valid = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  // Driver: present ID (plus WB for capture bypass), clock, then present EX-time MEM/WB and compare.
  task automatic apply_vec(input int idx, input vec_t v);
    id_valid = v.id_valid; id_pc = v.pc; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_rs1_data = v.rs1d; id_rs2_data = v.rs2d; id_imm = v.imm; id_alu_op = v.op;
    id_use_imm = v.use_imm; id_use_pc = v.use_pc; id_reg_write = v.rw;
    id_mem_read = 0; id_mem_write = 0;
    mem_valid = 0; mem_reg_write = 0;
    wb_valid = v.cwb_v; wb_reg_write = v.cwb_v; wb_rd = v.cwb_rd; wb_data = v.cwb_d;
    tick();
    id_valid = 0;
    mem_valid = v.m_v; mem_reg_write = v.m_rw; mem_rd = v.m_rd; mem_data = v.m_d;
    wb_valid = v.w_v; wb_reg_write = v.w_rw; wb_rd = v.w_rd; wb_data = v.w_d;
    #1;
    chk($sformatf("v%0d_valid", idx), {31'd0, ex_valid}, {31'd0, v.e_valid});
    chk($sformatf("v%0d_alu_a", idx), alu_a, v.e_a);
    chk($sformatf("v%0d_alu_b", idx), alu_b, v.e_b);
    chk($sformatf("v%0d_alu_op", idx), {28'd0, alu_op}, {28'd0, v.e_op});
    chk($sformatf("v%0d_store", idx), ex_store_data, v.e_sd);
  endtask

  task automatic load_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic rw, input logic mr, input logic mw);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_alu_op = 0; id_use_imm = 0; id_use_pc = 0;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  initial begin
    vec_t v;
    idle_inputs();

    v = '0; v.id_valid = 1; v.rs1 = 1; v.rs2 = 2; v.rd = 10; v.rs1d = 5; v.rs2d = 7; v.rw = 1;
    v.e_valid = 1; v.e_a = 5; v.e_b = 7; v.e_sd = 7; v.e_op = 0; vecs[0] = v;

    v = '0; v.id_valid = 1; v.rs1 = 3; v.rs2 = 4; v.rs2d = 32'h40; v.rw = 1;
    v.m_v = 1; v.m_rw = 1; v.m_rd = 3; v.m_d = 32'h11; v.w_v = 1; v.w_rw = 1; v.w_rd = 3; v.w_d = 32'h22;
    v.e_valid = 1; v.e_a = 32'h11; v.e_b = 32'h40; v.e_sd = 32'h40; vecs[1] = v;

    v.m_rd = 0; v.e_a = 32'h22; vecs[2] = v;

    v = '0; v.id_valid = 1; v.op = 9; v.use_imm = 1; v.imm = 32'hFFFF_FFF0;
    v.rs1 = 1; v.rs1d = 2; v.rs2 = 5; v.rs2d = 1; v.m_v = 1; v.m_rw = 1; v.m_rd = 5; v.m_d = 32'h77;
    v.e_valid = 1; v.e_a = 2; v.e_b = 32'hFFFF_FFF0; v.e_sd = 32'h77; v.e_op = 9; vecs[3] = v;

    v = '0; v.id_valid = 1; v.op = 4; v.use_pc = 1; v.pc = 32'h1000; v.rs1 = 6; v.rs1d = 3;
    v.rs2 = 2; v.rs2d = 9;
    v.e_valid = 1; v.e_a = 32'h1000; v.e_b = 9; v.e_sd = 9; v.e_op = 4; vecs[4] = v;

    v = '0; v.id_valid = 1; v.rs1 = 6; v.rs1d = 0; v.rs2 = 1; v.rs2d = 4;
    v.cwb_v = 1; v.cwb_rd = 6; v.cwb_d = 32'h99;
    v.e_valid = 1; v.e_a = 32'h99; v.e_b = 4; v.e_sd = 4; vecs[5] = v;

    v = '0; v.id_valid = 1; v.cwb_v = 1; v.cwb_rd = 0; v.cwb_d = 32'hAA;
    v.e_valid = 1; vecs[6] = v;

    v = '0; v.id_valid = 1; v.rs1 = 1; v.rs1d = 1; v.rs2 = 7; v.rs2d = 32'h12;
    v.w_v = 1; v.w_rw = 0; v.w_rd = 7; v.w_d = 32'h34;
    v.e_valid = 1; v.e_a = 1; v.e_b = 32'h12; v.e_sd = 32'h12; vecs[7] = v;

    v = '0; v.id_valid = 0; v.op = 8; v.rs1d = 5; v.rs2d = 6;
    v.e_valid = 0; v.e_a = 5; v.e_b = 6; v.e_sd = 6; v.e_op = 8; vecs[8] = v;

    v = '0; v.id_valid = 1; v.op = 7; v.rs1 = 9; v.rs1d = 32'hC0; v.rs2 = 10; v.rs2d = 32'hD0;
    v.m_v = 0; v.m_rw = 1; v.m_rd = 9; v.m_d = 32'hEE; v.w_v = 1; v.w_rw = 1; v.w_rd = 10; v.w_d = 32'hF0;
    v.e_valid = 1; v.e_a = 32'hC0; v.e_b = 32'hF0; v.e_sd = 32'hF0; v.e_op = 7; vecs[9] = v;

    v = '0; v.id_valid = 1; v.op = 5; v.rs1 = 1; v.rs1d = 2; v.rs2 = 11; v.rs2d = 1;
    v.m_v = 1; v.m_rw = 1; v.m_rd = 11; v.m_d = 32'h111; v.w_v = 1; v.w_rw = 1; v.w_rd = 11; v.w_d = 32'h222;
    v.e_valid = 1; v.e_a = 2; v.e_b = 32'h111; v.e_sd = 32'h111; v.e_op = 5; vecs[10] = v;

    rst = 1;
    #12;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_mem_write", {31'd0, ex_mem_write}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_stall", {31'd0, load_use_stall}, 32'd0);
    @(negedge clk);
    rst = 0;
    tick();

    for (int i = 0; i < 11; i++) apply_vec(i, vecs[i]);

    // Load-use: load x4 in EX, ID reads x4 as rs2.
    idle_inputs();
    load_id(5'd1, 5'd0, 5'd4, 32'd0, 32'd0, 1, 1, 0);
    tick();
    load_id(5'd9, 5'd4, 5'd12, 32'd3, 32'd0, 1, 0, 0);
    #1;
    chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_stall", {31'd0, load_use_stall}, 32'd0);
    tick();
    chk("lu_resume_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_resume_rd", {27'd0, ex_rd}, 32'd12);

    // Hold beats the stall; async reset mid-stall clears it.
    load_id(5'd1, 5'd0, 5'd4, 32'd0, 32'd0, 1, 1, 0);
    tick();
    load_id(5'd4, 5'd0, 5'd13, 32'd0, 32'd0, 1, 0, 0);
    hold = 1;
    tick();
    chk("hold_lu_valid", {31'd0, ex_valid}, 32'd1);
    chk("hold_lu_mem_read", {31'd0, ex_mem_read}, 32'd1);
    chk("hold_lu_stall", {31'd0, load_use_stall}, 32'd1);
    rst = 1;
    #1;
    chk("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_mid_stall", {31'd0, load_use_stall}, 32'd0);
    @(negedge clk);
    rst = 0;
    idle_inputs();

    // Load to x0 never stalls.
    load_id(5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 1, 1, 0);
    tick();
    load_id(5'd0, 5'd0, 5'd14, 32'd0, 32'd0, 1, 0, 0);
    #1;
    chk("x0_load_stall", {31'd0, load_use_stall}, 32'd0);

    // Hold refresh: WB forwards 0x55 to rs1 on the first held cycle only.
    load_id(5'd8, 5'd2, 5'd15, 32'd1, 32'd2, 1, 0, 0);
    tick();
    id_valid = 0;
    hold = 1;
    wb_valid = 1; wb_reg_write = 1; wb_rd = 8; wb_data = 32'h55;
    #1;
    chk("hold_fwd_a0", alu_a, 32'h55);
    tick();
    wb_valid = 0; wb_data = 0;
    #1;
    chk("hold_fwd_a1", alu_a, 32'h55);
    tick();
    tick();
    chk("hold_fwd_a2", alu_a, 32'h55);
    chk("hold_fwd_valid", {31'd0, ex_valid}, 32'd1);
    hold = 0;

    // Flush wins over hold for a valid store in EX.
    load_id(5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 0, 0, 1);
    tick();
    id_valid = 0;
    chk("store_mem_write", {31'd0, ex_mem_write}, 32'd1);
    flush = 1; hold = 1;
    tick();
    chk("flush_hold_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_hold_mem_write", {31'd0, ex_mem_write}, 32'd0);
    flush = 0; hold = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
